// File: rtl/width_combin_gen.sv
`default_nettype none
// ============================================================================
// Module      : width_combin_gen
// Description : Narrow-to-wide packer; NSIZE beats of DSIZE bits per word,
//               selectable lane order, partial-word flush with lane count.
//               Optional rd_keep lane mask: define WIDTH_COMBIN_GEN_KEEP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module width_combin_gen #(
    parameter int DSIZE     = 8,
    parameter int NSIZE     = 4,
    parameter int MSB_FIRST = 1,
    parameter int CSIZE     = $clog2(NSIZE + 1)
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic [DSIZE-1:0]       wr_data,
    input  logic                   wr_vld,
    output logic                   wr_ready,
    input  logic                   wr_last,
    input  logic                   wr_align_last,
    output logic [DSIZE*NSIZE-1:0] rd_data,
    output logic                   rd_vld,
    input  logic                   rd_ready,
    output logic                   rd_last,
    output logic [CSIZE-1:0]       rd_count
`ifdef WIDTH_COMBIN_GEN_KEEP_EN
    ,
    output logic [NSIZE-1:0]       rd_keep
`endif
);

    localparam int c_pw = (NSIZE > 1) ? $clog2(NSIZE) : 1;
    localparam int c_w  = DSIZE * NSIZE;

    logic [c_pw-1:0] r_point;
    logic [c_w-1:0]  r_acc;
    logic [c_w-1:0]  w_merged;
    logic            w_accept;
    logic            w_complete;

    assign wr_ready   = ~rst & (~rd_vld | rd_ready);
    assign w_accept   = wr_vld & wr_ready;
    assign w_complete = w_accept &
                        ((r_point == c_pw'(NSIZE - 1)) | wr_last | wr_align_last);

    // Logical lane k maps to a physical bit slice depending on lane order.
    generate
        for (genvar k = 0; k < NSIZE; k++) begin : g_lane
            localparam int c_pos = (MSB_FIRST != 0) ? (NSIZE - 1 - k) : k;
            assign w_merged[c_pos*DSIZE +: DSIZE] =
                (r_point == c_pw'(k)) ? wr_data : r_acc[c_pos*DSIZE +: DSIZE];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (rst) begin
            r_point  <= '0;
            r_acc    <= '0;
            rd_data  <= '0;
            rd_vld   <= 1'b0;
            rd_last  <= 1'b0;
            rd_count <= '0;
        end else begin
            if (w_accept) begin
                if (w_complete) begin
                    r_point <= '0;
                    r_acc   <= '0;
                end else begin
                    r_point <= r_point + c_pw'(1);
                    r_acc   <= w_merged;
                end
            end

            // Loading wins over consuming so back-to-back words never bubble.
            if (w_complete) begin
                rd_data  <= w_merged;
                rd_vld   <= 1'b1;
                rd_last  <= wr_last;
                rd_count <= CSIZE'(r_point) + CSIZE'(1);
            end else if (rd_ready) begin
                rd_vld <= 1'b0;
            end
        end
    end

`ifdef WIDTH_COMBIN_GEN_KEEP_EN
    logic [NSIZE-1:0] w_keep;

    always_comb begin
        w_keep = '0;
        for (int i = 0; i < NSIZE; i++) begin
            if (MSB_FIRST != 0)
                w_keep[i] = ((NSIZE - 1 - i) <= int'(r_point));
            else
                w_keep[i] = (i <= int'(r_point));
        end
    end

    always_ff @(posedge clock) begin
        if (rst)
            rd_keep <= '0;
        else if (w_complete)
            rd_keep <= w_keep;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_width_combin_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_width_combin_gen
// Description : Directed bench for width_combin_gen, MSB-first and LSB-first
//               instances sharing one input stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_width_combin_gen;

    logic        clock = 1'b0;
    logic        rst;
    logic [7:0]  wr_data;
    logic        wr_vld;
    logic        wr_last;
    logic        wr_align_last;
    logic        rd_ready;

    logic        m_wr_ready, l_wr_ready;
    logic [31:0] m_rd_data, l_rd_data;
    logic        m_rd_vld, l_rd_vld;
    logic        m_rd_last, l_rd_last;
    logic [2:0]  m_rd_count, l_rd_count;
`ifdef WIDTH_COMBIN_GEN_KEEP_EN
    logic [3:0]  m_rd_keep, l_rd_keep;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    width_combin_gen #(.DSIZE(8), .NSIZE(4), .MSB_FIRST(1)) u_msb (
        .clock(clock), .rst(rst), .wr_data(wr_data), .wr_vld(wr_vld),
        .wr_ready(m_wr_ready), .wr_last(wr_last), .wr_align_last(wr_align_last),
        .rd_data(m_rd_data), .rd_vld(m_rd_vld), .rd_ready(rd_ready),
        .rd_last(m_rd_last), .rd_count(m_rd_count)
`ifdef WIDTH_COMBIN_GEN_KEEP_EN
        , .rd_keep(m_rd_keep)
`endif
    );

    width_combin_gen #(.DSIZE(8), .NSIZE(4), .MSB_FIRST(0)) u_lsb (
        .clock(clock), .rst(rst), .wr_data(wr_data), .wr_vld(wr_vld),
        .wr_ready(l_wr_ready), .wr_last(wr_last), .wr_align_last(wr_align_last),
        .rd_data(l_rd_data), .rd_vld(l_rd_vld), .rd_ready(rd_ready),
        .rd_last(l_rd_last), .rd_count(l_rd_count)
`ifdef WIDTH_COMBIN_GEN_KEEP_EN
        , .rd_keep(l_rd_keep)
`endif
    );

    // Present one beat and step past the next rising edge.
    task automatic beat(input logic [7:0] d, input logic l, input logic a);
        wr_data = d; wr_vld = 1'b1; wr_last = l; wr_align_last = a;
        @(posedge clock); #1;
    endtask

    task automatic idle(input int n);
        wr_vld = 1'b0; wr_last = 1'b0; wr_align_last = 1'b0; wr_data = 8'h00;
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic test_reset();
        rst = 1'b1; rd_ready = 1'b1;
        idle(2);
        n_vec++; if (m_rd_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld got %0b exp 0", m_rd_vld); end
        n_vec++; if (m_rd_data !== 32'h0) begin n_err++; $display("FAIL reset_data got %h exp 0", m_rd_data); end
        n_vec++; if (m_rd_count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", m_rd_count); end
        n_vec++; if (m_rd_last !== 1'b0) begin n_err++; $display("FAIL reset_last got %0b exp 0", m_rd_last); end
        n_vec++; if (m_wr_ready !== 1'b0) begin n_err++; $display("FAIL reset_wr_ready got %0b exp 0", m_wr_ready); end
`ifdef WIDTH_COMBIN_GEN_KEEP_EN
        n_vec++; if (m_rd_keep !== 4'h0) begin n_err++; $display("FAIL reset_keep got %h exp 0", m_rd_keep); end
`endif
        rst = 1'b0;
        #1;
        n_vec++; if (m_wr_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_wr_ready got %0b exp 1", m_wr_ready); end
    endtask

    task automatic test_full_word();
        beat(8'h11, 0, 0); beat(8'h22, 0, 0); beat(8'h33, 0, 0);
        n_vec++; if (m_rd_vld !== 1'b0) begin n_err++; $display("FAIL full_early_vld got %0b exp 0", m_rd_vld); end
        beat(8'h44, 0, 0);
        n_vec++; if (m_rd_data !== 32'h11223344) begin n_err++; $display("FAIL full_msb_data got %h exp 11223344", m_rd_data); end
        n_vec++; if (m_rd_vld !== 1'b1) begin n_err++; $display("FAIL full_vld got %0b exp 1", m_rd_vld); end
        n_vec++; if (m_rd_count !== 3'd4) begin n_err++; $display("FAIL full_count got %0d exp 4", m_rd_count); end
        n_vec++; if (m_rd_last !== 1'b0) begin n_err++; $display("FAIL full_last got %0b exp 0", m_rd_last); end
        n_vec++; if (l_rd_data !== 32'h44332211) begin n_err++; $display("FAIL full_lsb_data got %h exp 44332211", l_rd_data); end
        n_vec++; if (l_rd_count !== 3'd4) begin n_err++; $display("FAIL full_lsb_count got %0d exp 4", l_rd_count); end
`ifdef WIDTH_COMBIN_GEN_KEEP_EN
        n_vec++; if (m_rd_keep !== 4'hF) begin n_err++; $display("FAIL full_keep got %h exp F", m_rd_keep); end
`endif
        idle(1);
        n_vec++; if (m_rd_vld !== 1'b0) begin n_err++; $display("FAIL full_consumed_vld got %0b exp 0", m_rd_vld); end
    endtask

    task automatic test_partial_last();
        beat(8'hAA, 0, 0); beat(8'hBB, 1, 0);
        n_vec++; if (m_rd_data !== 32'hAABB0000) begin n_err++; $display("FAIL part_msb_data got %h exp AABB0000", m_rd_data); end
        n_vec++; if (m_rd_count !== 3'd2) begin n_err++; $display("FAIL part_count got %0d exp 2", m_rd_count); end
        n_vec++; if (m_rd_last !== 1'b1) begin n_err++; $display("FAIL part_last got %0b exp 1", m_rd_last); end
        n_vec++; if (l_rd_data !== 32'h0000BBAA) begin n_err++; $display("FAIL part_lsb_data got %h exp 0000BBAA", l_rd_data); end
`ifdef WIDTH_COMBIN_GEN_KEEP_EN
        n_vec++; if (m_rd_keep !== 4'b1100) begin n_err++; $display("FAIL part_msb_keep got %b exp 1100", m_rd_keep); end
        n_vec++; if (l_rd_keep !== 4'b0011) begin n_err++; $display("FAIL part_lsb_keep got %b exp 0011", l_rd_keep); end
`endif
        // Single-beat packet also proves the next beat lands in the top lane.
        beat(8'hCC, 1, 0);
        n_vec++; if (m_rd_data !== 32'hCC000000) begin n_err++; $display("FAIL one_lane_data got %h exp CC000000", m_rd_data); end
        n_vec++; if (m_rd_count !== 3'd1) begin n_err++; $display("FAIL one_lane_count got %0d exp 1", m_rd_count); end
        n_vec++; if (m_rd_vld !== 1'b1) begin n_err++; $display("FAIL one_lane_vld got %0b exp 1", m_rd_vld); end
        idle(1);
    endtask

    task automatic test_align_flags();
        beat(8'h01, 0, 0); beat(8'h02, 0, 1);
        n_vec++; if (m_rd_data !== 32'h01020000) begin n_err++; $display("FAIL align_data got %h exp 01020000", m_rd_data); end
        n_vec++; if (m_rd_last !== 1'b0) begin n_err++; $display("FAIL align_last got %0b exp 0", m_rd_last); end
        n_vec++; if (m_rd_count !== 3'd2) begin n_err++; $display("FAIL align_count got %0d exp 2", m_rd_count); end
        beat(8'h03, 1, 1);
        n_vec++; if (m_rd_last !== 1'b1) begin n_err++; $display("FAIL both_flags_last got %0b exp 1", m_rd_last); end
        n_vec++; if (m_rd_data !== 32'h03000000) begin n_err++; $display("FAIL both_flags_data got %h exp 03000000", m_rd_data); end
        // Flags without wr_vld must not close a word.
        wr_vld = 1'b0; wr_last = 1'b1; wr_align_last = 1'b1; wr_data = 8'hEE;
        @(posedge clock); #1;
        beat(8'h04, 0, 0); beat(8'h05, 0, 0); beat(8'h06, 0, 0);
        n_vec++; if (m_rd_vld !== 1'b0) begin n_err++; $display("FAIL ignored_flag_vld got %0b exp 0", m_rd_vld); end
        beat(8'h07, 0, 0);
        n_vec++; if (m_rd_data !== 32'h04050607) begin n_err++; $display("FAIL ignored_flag_data got %h exp 04050607", m_rd_data); end
        n_vec++; if (m_rd_count !== 3'd4) begin n_err++; $display("FAIL ignored_flag_count got %0d exp 4", m_rd_count); end
        idle(1);
    endtask

    task automatic test_backpressure();
        rd_ready = 1'b1;
        beat(8'h11, 0, 0); beat(8'h22, 0, 0); beat(8'h33, 0, 0);
        rd_ready = 1'b0;
        beat(8'h44, 0, 0);
        wr_data = 8'h55; wr_vld = 1'b1; wr_last = 1'b0; wr_align_last = 1'b0;
        #1;
        n_vec++; if (m_wr_ready !== 1'b0) begin n_err++; $display("FAIL stall_wr_ready got %0b exp 0", m_wr_ready); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            n_vec++; if (m_rd_vld !== 1'b1 || m_rd_data !== 32'h11223344 || m_rd_count !== 3'd4)
                begin n_err++; $display("FAIL stall_hold[%0d] got vld=%0b data=%h cnt=%0d exp 1 11223344 4", i, m_rd_vld, m_rd_data, m_rd_count); end
        end
        rd_ready = 1'b1;
        #1;
        n_vec++; if (m_wr_ready !== 1'b1) begin n_err++; $display("FAIL release_wr_ready got %0b exp 1", m_wr_ready); end
        @(posedge clock); #1;
        n_vec++; if (m_rd_vld !== 1'b0) begin n_err++; $display("FAIL release_vld got %0b exp 0", m_rd_vld); end
        beat(8'h66, 0, 0); beat(8'h77, 0, 0); beat(8'h88, 0, 0);
        n_vec++; if (m_rd_data !== 32'h55667788) begin n_err++; $display("FAIL resume_data got %h exp 55667788", m_rd_data); end
        idle(1);
    endtask

    task automatic test_back_to_back();
        rd_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            beat(8'(i), 0, 0);
            n_vec++; if (m_wr_ready !== 1'b1) begin n_err++; $display("FAIL b2b_wr_ready[%0d] got %0b exp 1", i, m_wr_ready); end
            if (i == 4) begin
                n_vec++; if (m_rd_vld !== 1'b1 || m_rd_data !== 32'h01020304) begin n_err++; $display("FAIL b2b_word0 got vld=%0b data=%h exp 1 01020304", m_rd_vld, m_rd_data); end
            end
            if (i == 5) begin
                n_vec++; if (m_rd_vld !== 1'b0) begin n_err++; $display("FAIL b2b_gap_vld got %0b exp 0", m_rd_vld); end
            end
        end
        n_vec++; if (m_rd_vld !== 1'b1 || m_rd_data !== 32'h05060708) begin n_err++; $display("FAIL b2b_word1 got vld=%0b data=%h exp 1 05060708", m_rd_vld, m_rd_data); end
        // Consume and load in the same cycle.
        beat(8'h09, 1, 0);
        beat(8'h0A, 1, 0);
        n_vec++; if (m_rd_vld !== 1'b1 || m_rd_data !== 32'h0A000000) begin n_err++; $display("FAIL swap_word got vld=%0b data=%h exp 1 0A000000", m_rd_vld, m_rd_data); end
        idle(1);
    endtask

    task automatic test_reset_mid();
        rd_ready = 1'b1;
        beat(8'h99, 0, 0); beat(8'hAA, 0, 0);
        wr_vld = 1'b0; rst = 1'b1;
        @(posedge clock); #1;
        n_vec++; if (m_rd_vld !== 1'b0) begin n_err++; $display("FAIL midrst_vld got %0b exp 0", m_rd_vld); end
        rst = 1'b0;
        beat(8'h55, 0, 0); beat(8'h66, 0, 0); beat(8'h77, 0, 0); beat(8'h88, 0, 0);
        n_vec++; if (m_rd_data !== 32'h55667788) begin n_err++; $display("FAIL midrst_data got %h exp 55667788", m_rd_data); end
        n_vec++; if (l_rd_data !== 32'h88776655) begin n_err++; $display("FAIL midrst_lsb_data got %h exp 88776655", l_rd_data); end
        // Reset drops a pending, unconsumed word.
        rd_ready = 1'b0;
        wr_vld = 1'b0; rst = 1'b1;
        @(posedge clock); #1;
        n_vec++; if (m_rd_vld !== 1'b0 || m_rd_data !== 32'h0) begin n_err++; $display("FAIL pendrst got vld=%0b data=%h exp 0 0", m_rd_vld, m_rd_data); end
        rst = 1'b0; rd_ready = 1'b1;
        idle(1);
    endtask

    initial begin
        wr_data = 8'h00; wr_vld = 1'b0; wr_last = 1'b0; wr_align_last = 1'b0;
        rd_ready = 1'b1; rst = 1'b1;
        test_reset();
        test_full_word();
        test_partial_last();
        test_align_flags();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
